// File: rtl/cache_mem_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter_pkg
// Shared definitions for the cache/memory arbiter: FSM state encoding,
// default address/line widths and the requester identifiers used by the
// grant logic.
// No ports (package).
// ---------------------------------------------------------------------------
package cache_mem_arbiter_pkg;

  // Block address width (16-byte lines) and cache line width defaults
  localparam int ADDR_W_DEFAULT = 28;
  localparam int LINE_W_DEFAULT = 128;

  // Arbiter FSM states; encoding is fixed so debug tools can decode it
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RELEASE = 2'd3
  } arb_state_e;

  // Requester identifiers
  typedef logic req_id_t;
  localparam req_id_t REQ_I = 1'b0;
  localparam req_id_t REQ_D = 1'b1;

endpackage

// File: rtl/cache_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cache_mem_arbiter
// Shares one line-wide memory port between an I-cache (reads only) and a
// D-cache (reads and writebacks). One transaction at a time; every output is
// registered.
//
// Build option: define CACHE_ARB_RR_EN to switch simultaneous-request
// arbitration from fixed D-over-I priority to round-robin with a 1-bit
// pointer that favours the side not granted last.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   i_req, i_addr         I-cache line read request / block address
//   i_ready, i_rdata      I completion pulse / refill line (held)
//   d_read, d_write       D-cache read / writeback request (both = write)
//   d_addr, d_wdata       D-cache block address / writeback line
//   d_ready, d_rdata      D completion pulse / refill line (held)
//   mem_read, mem_write   memory strobes, level, held until mem_ready
//   mem_addr, mem_wdata   memory block address / write line
//   mem_rdata, mem_ready  memory read line / one-cycle completion
// ---------------------------------------------------------------------------
module cache_mem_arbiter
  import cache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LINE_W = LINE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_e        state_q, state_d;
  logic              iReady_q, iReady_d;
  logic              dReady_q, dReady_d;
  logic              memRead_q, memRead_d;
  logic              memWrite_q, memWrite_d;
  logic [ADDR_W-1:0] memAddr_q, memAddr_d;
  logic [LINE_W-1:0] memWdata_q, memWdata_d;
  logic [LINE_W-1:0] iRdata_q, iRdata_d;
  logic [LINE_W-1:0] dRdata_q, dRdata_d;
  logic              dReqAny;
  req_id_t           grant;

`ifdef CACHE_ARB_RR_EN
  req_id_t           ptr_q, ptr_d;
`endif

  assign dReqAny = d_read | d_write;

  // Grant selection: which side wins if IDLE sees a request this cycle.
  // A lone requester always wins; on a conflict either D wins outright or
  // the round-robin pointer decides.
  always_comb begin
    grant = REQ_I;
`ifdef CACHE_ARB_RR_EN
    if (dReqAny && (!i_req || ptr_q == REQ_D)) begin
      grant = REQ_D;
    end
`else
    if (dReqAny) begin
      grant = REQ_D;
    end
`endif
  end

  // Next-state and registered-output logic. The winner's address, data and
  // operation are latched on the grant so later requester changes cannot
  // disturb the memory access. Completion drops the strobes and raises the
  // ready pulse on the same edge; RELEASE then gives the requester one
  // cycle to deassert before IDLE arbitrates again.
  always_comb begin
    state_d    = state_q;
    iReady_d   = 1'b0;
    dReady_d   = 1'b0;
    memRead_d  = memRead_q;
    memWrite_d = memWrite_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    iRdata_d   = iRdata_q;
    dRdata_d   = dRdata_q;
`ifdef CACHE_ARB_RR_EN
    ptr_d      = ptr_q;
`endif

    case (state_q)
      IDLE: begin
        if (i_req || dReqAny) begin
          if (grant == REQ_D) begin
            state_d    = SERVE_D;
            memAddr_d  = d_addr;
            memWrite_d = d_write;
            memRead_d  = !d_write;
            if (d_write) begin
              memWdata_d = d_wdata;
            end
          end else begin
            state_d    = SERVE_I;
            memAddr_d  = i_addr;
            memRead_d  = 1'b1;
            memWrite_d = 1'b0;
          end
`ifdef CACHE_ARB_RR_EN
          ptr_d = (grant == REQ_D) ? REQ_I : REQ_D;
`endif
        end
      end

      SERVE_I: begin
        if (mem_ready) begin
          iRdata_d   = mem_rdata;
          iReady_d   = 1'b1;
          memRead_d  = 1'b0;
          memWrite_d = 1'b0;
          state_d    = RELEASE;
        end
      end

      SERVE_D: begin
        if (mem_ready) begin
          // A writeback completion must leave the refill line untouched
          if (memRead_q) begin
            dRdata_d = mem_rdata;
          end
          dReady_d   = 1'b1;
          memRead_d  = 1'b0;
          memWrite_d = 1'b0;
          state_d    = RELEASE;
        end
      end

      RELEASE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset abandons any in-flight access so a late
  // mem_ready lands in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      iReady_q   <= 1'b0;
      dReady_q   <= 1'b0;
      memRead_q  <= 1'b0;
      memWrite_q <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      iRdata_q   <= '0;
      dRdata_q   <= '0;
`ifdef CACHE_ARB_RR_EN
      ptr_q      <= REQ_D;
`endif
    end else begin
      state_q    <= state_d;
      iReady_q   <= iReady_d;
      dReady_q   <= dReady_d;
      memRead_q  <= memRead_d;
      memWrite_q <= memWrite_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      iRdata_q   <= iRdata_d;
      dRdata_q   <= dRdata_d;
`ifdef CACHE_ARB_RR_EN
      ptr_q      <= ptr_d;
`endif
    end
  end

  assign i_ready   = iReady_q;
  assign i_rdata   = iRdata_q;
  assign d_ready   = dReady_q;
  assign d_rdata   = dRdata_q;
  assign mem_read  = memRead_q;
  assign mem_write = memWrite_q;
  assign mem_addr  = memAddr_q;
  assign mem_wdata = memWdata_q;

endmodule
